// File: rtl/apb_requester_if.sv
// apb_requester_if: core command/response port plus the APB completer bus of the APB requester bridge.
interface apb_requester_if #(
  parameter int ADDR_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [31:0]       cmd_wdata;
  logic [3:0]        cmd_strb;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;
  logic              psel;
  logic              penable;
  logic [ADDR_W-1:0] paddr;
  logic              pwrite;
  logic [31:0]       pwdata;
  logic [3:0]        pstrb;
  logic [2:0]        pprot;
  logic [31:0]       prdata;
  logic              pready;
  logic              pslverr;
  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, prdata, pready, pslverr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output psel, penable, paddr, pwrite, pwdata, pstrb, pprot
  );
  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, prdata, pready, pslverr,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  psel, penable, paddr, pwrite, pwdata, pstrb, pprot
  );
endinterface

// File: rtl/apb_requester.sv
// apb_requester: turns each core command into one APB SETUP/ACCESS transfer with wait states and timeout abort.
module apb_requester #(
  parameter int         ADDR_W      = 8,
  parameter int         TIMEOUT_CYC = 16,
  parameter logic [2:0] PPROT_VAL   = 3'b000
) (
  input logic             pclk,
  input logic             preset_n,
  apb_requester_if.master bus
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam int CW = TIMEOUT_CYC > 1 ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC > 0 ? TIMEOUT_CYC - 1 : 0);
  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic              pwrite_q, pwrite_d;
  logic [31:0]       pwdata_q, pwdata_d;
  logic [3:0]        pstrb_q, pstrb_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_timeout_q, rsp_timeout_d;
  logic              timeout_hit;
  assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt_q == CNT_LAST);
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    paddr_d       = paddr_q;
    pwrite_d      = pwrite_q;
    pwdata_d      = pwdata_q;
    pstrb_d       = pstrb_q;
    rsp_valid_d   = 1'b0;
    rsp_err_d     = 1'b0;
    rsp_timeout_d = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    case (state_q)
      IDLE: if (bus.cmd_valid) begin
        state_d  = SETUP;
        psel_d   = 1'b1;
        paddr_d  = bus.cmd_addr;
        pwrite_d = bus.cmd_write;
        pwdata_d = bus.cmd_wdata;
        pstrb_d  = bus.cmd_write ? bus.cmd_strb : 4'b0000;
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
        cnt_d     = '0;
      end
      ACCESS: if (bus.pready || timeout_hit) begin
        // a completed transfer wins over a timeout landing on the same edge
        state_d       = IDLE;
        psel_d        = 1'b0;
        penable_d     = 1'b0;
        rsp_valid_d   = 1'b1;
        rsp_err_d     = !bus.pready || bus.pslverr;
        rsp_timeout_d = !bus.pready;
        rsp_rdata_d   = pwrite_q ? rsp_rdata_q : bus.pready ? bus.prdata : 32'h0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      default: begin
        state_d   = IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      paddr_q       <= '0;
      pwrite_q      <= 1'b0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      paddr_q       <= paddr_d;
      pwrite_q      <= pwrite_d;
      pwdata_q      <= pwdata_d;
      pstrb_q       <= pstrb_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end
  assign bus.cmd_ready   = state_q == IDLE;
  assign bus.psel        = psel_q;
  assign bus.penable     = penable_q;
  assign bus.paddr       = paddr_q;
  assign bus.pwrite      = pwrite_q;
  assign bus.pwdata      = pwdata_q;
  assign bus.pstrb       = pstrb_q;
  assign bus.pprot       = PPROT_VAL;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_timeout = rsp_timeout_q;
endmodule

// File: tb/tb_apb_requester.sv
// tb_apb_requester: directed transfers checked every cycle against a transaction-timeline model of the bridge.
module tb_apb_requester;
  localparam int         TO   = 4;
  localparam logic [2:0] PROT = 3'b010;
  localparam int         NT   = 9;
  logic clk, preset_n;
  apb_requester_if #(.ADDR_W(8)) bus();
  apb_requester #(.ADDR_W(8), .TIMEOUT_CYC(TO), .PPROT_VAL(PROT)) dut (
    .pclk(clk), .preset_n(preset_n), .bus(bus)
  );
  // transfer table; t_bb marks a command presented while the previous one is still in flight
  bit          t_wr   [NT] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [7:0]  t_addr [NT] = '{8'h08, 8'h08, 8'h10, 8'h14, 8'h0C, 8'h0C, 8'h20, 8'h30, 8'h40};
  logic [31:0] t_wdata[NT] = '{32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 32'h0000AB00, 32'h0, 32'hCAFEF00D, 32'h0, 32'h01020304};
  logic [3:0]  t_strb [NT] = '{4'hF, 4'hA, 4'h0, 4'hF, 4'h2, 4'h5, 4'h3, 4'hF, 4'hC};
  int          t_wait [NT] = '{0, 0, 3, 100, 0, 1, 2, 100, 0};
  logic [31:0] t_rd   [NT] = '{32'h0, 32'hDEADBEEF, 32'h12345678, 32'hFFFFFFFF, 32'h0, 32'h5A5A5A5A, 32'h0, 32'h0, 32'h0};
  bit          t_err  [NT] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  bit          t_bb   [NT] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  int vectors = 0, miscompares = 0;
  int cyc = 0, t0 = -1000, n = 0, cur = 0, acc_cnt = 0, run = 0;
  bit e_wr = 1'b0, e_err = 1'b0, busy, rsp_c, in_acc, hit, prev_psel = 1'b0;
  logic [7:0]  e_addr = '0;
  logic [31:0] e_wdata = '0, e_rd = '0, exp_rdata = '0;
  logic [3:0]  e_strb = '0;
  int          e_wait = 0;
  bit          got    [NT] = '{default: 1'b0};
  bit          c_err  [NT] = '{default: 1'b0};
  bit          c_to   [NT] = '{default: 1'b0};
  logic [31:0] c_rdata[NT] = '{default: 32'h0};
  int          c_lat  [NT] = '{default: 0};
  int          c_pen  [NT] = '{default: 0};
  int          c_gap  [NT] = '{default: 0};
  int          acc_c  [NT] = '{default: 0};
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
    $fatal(1);
  end
  // model, compare and completer: all evaluated mid-cycle on the falling edge
  initial forever begin
    @(negedge clk);
    cyc++;
    busy  = cyc >= t0 && cyc <= t0 + n;
    rsp_c = cyc == t0 + n + 1;
    if (!preset_n) begin
      t0 = -1000;
      exp_rdata = '0;
    end else begin
      if (rsp_c && !e_wr) exp_rdata = (e_wait >= TO) ? 32'h0 : e_rd;
      chk("cmd_ready", 32'(bus.cmd_ready), 32'(!busy));
      chk("psel", 32'(bus.psel), 32'(busy));
      chk("penable", 32'(bus.penable), 32'(cyc > t0 && cyc <= t0 + n));
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(rsp_c));
      chk("rsp_err", 32'(bus.rsp_err), 32'(rsp_c && (e_wait >= TO || e_err)));
      chk("rsp_timeout", 32'(bus.rsp_timeout), 32'(rsp_c && e_wait >= TO));
      chk("rsp_rdata", bus.rsp_rdata, exp_rdata);
      chk("pprot", 32'(bus.pprot), 32'(PROT));
      if (busy) begin
        chk("paddr", 32'(bus.paddr), 32'(e_addr));
        chk("pwrite", 32'(bus.pwrite), 32'(e_wr));
        chk("pwdata", bus.pwdata, e_wdata);
        chk("pstrb", 32'(bus.pstrb), 32'(e_wr ? e_strb : 4'h0));
      end
      if (bus.rsp_valid) begin
        got[cur]     = 1'b1;
        c_err[cur]   = bus.rsp_err;
        c_to[cur]    = bus.rsp_timeout;
        c_rdata[cur] = bus.rsp_rdata;
        c_lat[cur]   = cyc - acc_c[cur];
      end
      if (bus.penable) c_pen[cur]++;
      if (bus.psel && !prev_psel) c_gap[cur] = run;
      run = bus.psel ? 0 : run + 1;
      prev_psel = bus.psel;
    end
    in_acc = preset_n && cyc > t0 && cyc <= t0 + n;
    hit = in_acc && (cyc - t0 - 1 == e_wait);
    bus.pready  = in_acc ? hit : 1'($urandom);
    bus.prdata  = hit ? e_rd : $urandom;
    bus.pslverr = hit ? e_err : 1'($urandom);
    if (preset_n && bus.cmd_valid && !busy && acc_cnt < NT) begin
      cur        = acc_cnt;
      acc_c[cur] = cyc;
      t0         = cyc + 1;
      e_wr       = bus.cmd_write;
      e_addr     = bus.cmd_addr;
      e_wdata    = bus.cmd_wdata;
      e_strb     = bus.cmd_strb;
      e_wait     = t_wait[cur];
      e_rd       = t_rd[cur];
      e_err      = t_err[cur];
      n          = (e_wait >= TO) ? TO : e_wait + 1;
      acc_cnt++;
    end
  end
  initial begin
    preset_n = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.cmd_strb  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_psel", 32'(bus.psel), 32'd0);
    chk("rst_penable", 32'(bus.penable), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_paddr", 32'(bus.paddr), 32'd0);
    chk("rst_pwdata", bus.pwdata, 32'd0);
    chk("rst_pstrb", 32'(bus.pstrb), 32'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("rst_pprot", 32'(bus.pprot), 32'(PROT));
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    preset_n = 1'b1;
    for (int i = 0; i < NT; i++) begin
      if (!t_bb[i]) begin
        @(posedge clk);
        #1;
      end
      bus.cmd_valid = 1'b1;
      bus.cmd_write = t_wr[i];
      bus.cmd_addr  = t_addr[i];
      bus.cmd_wdata = t_wdata[i];
      bus.cmd_strb  = t_strb[i];
      for (int k = 0; k < 20 && acc_cnt <= i; k++) begin
        @(posedge clk);
        #1;
      end
      chk("accept", 32'(acc_cnt > i), 32'd1);
      if (i + 1 < NT && t_bb[i+1]) continue;
      bus.cmd_valid = 1'b0;
      bus.cmd_write = 1'($urandom);
      bus.cmd_addr  = 8'($urandom);
      bus.cmd_wdata = $urandom;
      bus.cmd_strb  = 4'($urandom);
      if (i == 7) begin
        repeat (2) @(posedge clk);
        #3;
        preset_n = 1'b0;
        #1;
        chk("midrst_psel", 32'(bus.psel), 32'd0);
        chk("midrst_penable", 32'(bus.penable), 32'd0);
        chk("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("midrst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        preset_n = 1'b1;
        repeat (8) @(posedge clk);
        chk("no_stale_rsp", 32'(got[7]), 32'd0);
      end else begin
        for (int k = 0; k < 30 && !got[i]; k++) @(posedge clk);
        chk("rsp_seen", 32'(got[i]), 32'd1);
      end
    end
    repeat (3) @(posedge clk);
    chk("lat_w0", 32'(c_lat[0]), 32'd3);
    chk("pen_w0", 32'(c_pen[0]), 32'd1);
    chk("err_w0", 32'(c_err[0]), 32'd0);
    chk("rdata_r1", c_rdata[1], 32'hDEADBEEF);
    chk("lat_r1", 32'(c_lat[1]), 32'd3);
    chk("pen_wait2", 32'(c_pen[2]), 32'd4);
    chk("rdata_wait2", c_rdata[2], 32'h12345678);
    chk("to_wait2", 32'(c_to[2]), 32'd0);
    chk("pen_to3", 32'(c_pen[3]), 32'd4);
    chk("err_to3", 32'(c_err[3]), 32'd1);
    chk("to_to3", 32'(c_to[3]), 32'd1);
    chk("rdata_to3", c_rdata[3], 32'h0);
    chk("err_slverr4", 32'(c_err[4]), 32'd1);
    chk("err_bb5", 32'(c_err[5]), 32'd0);
    chk("gap_bb5", 32'(c_gap[5]), 32'd1);
    chk("rdata_bb5", c_rdata[5], 32'h5A5A5A5A);
    chk("rdata_w6_kept", c_rdata[6], 32'h5A5A5A5A);
    chk("lat_postrst8", 32'(c_lat[8]), 32'd3);
    chk("err_postrst8", 32'(c_err[8]), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
